// File: rtl/prbs_pattern_tx.sv
// prbs_pattern_tx: transmit side of the PRBS link.
// On start it sends a 32-bit framing pattern n times (MSB byte first), then
// prbs_bytes bytes of PRBS-15 (x^15 + x^14 + 1). The output is a byte stream
// with a valid/ready handshake.
// Optional build macro PRBS_TX_ERR_INJECT_EN adds an err_inject input. Each
// pulse on it inverts bit 0 of exactly one later byte. Use it to check that
// the detector rejects corrupted frames.

module prbs_pattern_tx #(
   parameter logic [14:0] SEED       = 15'h7FFF,
   parameter int          PRBS_LEN_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [31:0]           pattern,
   input  logic [3:0]            n,
   input  logic [PRBS_LEN_W-1:0] prbs_bytes,
   output logic [7:0]            data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic                  done
`ifdef PRBS_TX_ERR_INJECT_EN
   ,
   input  logic                  err_inject
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PAT  = 2'd1,
      PRBS = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Eight LFSR steps. The result is {next_state, byte}.
   // The first generated bit ends up in byte[7].
   function automatic logic [22:0] prbs_step8(input logic [14:0] s);
      logic [14:0] st;
      logic [7:0]  b;
      logic        fb;
      st = s;
      b  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         fb = st[14] ^ st[13];
         st = {st[13:0], fb};
         b  = {b[6:0], fb};
      end
      return {st, b};
   endfunction

   state_t                  state_reg;
   logic [31:0]             pattern_reg;
   logic [3:0]              n_reg;
   logic [PRBS_LEN_W-1:0]   prbs_len_reg;
   logic [1:0]              byte_idx_reg;
   logic [3:0]              rep_cnt_reg;
   logic [PRBS_LEN_W-1:0]   prbs_cnt_reg;
   logic [14:0]             lfsr_reg;
   logic [7:0]              data_reg;
   logic                    data_valid_reg;
   logic                    busy_reg;
   logic                    done_reg;

   logic                    transfer;
   logic [1:0]              byte_idx_next;
   logic [3:0]              rep_cnt_next;
   logic [PRBS_LEN_W-1:0]   prbs_cnt_next;
   logic                    rep_last;
   logic                    prbs_last;
   logic [22:0]             seed_step;
   logic [22:0]             lfsr_step;
   logic [7:0]              pat_bytes [4];

   // Split the latched pattern into bytes. Index 0 is the byte sent first ([31:24]).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pat_bytes
         assign pat_bytes[gi] = pattern_reg[31-8*gi -: 8];
      end
   endgenerate

   assign transfer      = data_valid_reg && data_ready;
   assign byte_idx_next = byte_idx_reg + 2'd1;
   assign rep_cnt_next  = rep_cnt_reg + 4'd1;
   assign prbs_cnt_next = prbs_cnt_reg + {{(PRBS_LEN_W-1){1'b0}}, 1'b1};
   assign rep_last      = (rep_cnt_next == n_reg);
   assign prbs_last     = (prbs_cnt_next == prbs_len_reg);

   // Precompute the next PRBS byte. The byte after the current one is then
   // ready on the same edge that accepts the current one, so there is no
   // stall cycle.
   assign seed_step = prbs_step8(SEED);
   assign lfsr_step = prbs_step8(lfsr_reg);

   // Main sequencer. All outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         pattern_reg    <= 32'h0;
         n_reg          <= 4'h0;
         prbs_len_reg   <= '0;
         byte_idx_reg   <= 2'd0;
         rep_cnt_reg    <= 4'd0;
         prbs_cnt_reg   <= '0;
         lfsr_reg       <= SEED;
         data_reg       <= 8'h00;
         data_valid_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  pattern_reg  <= pattern;
                  n_reg        <= n;
                  prbs_len_reg <= prbs_bytes;
                  byte_idx_reg <= 2'd0;
                  rep_cnt_reg  <= 4'd0;
                  prbs_cnt_reg <= '0;
                  if (n != 4'd0) begin
                     state_reg      <= PAT;
                     lfsr_reg       <= SEED;
                     data_reg       <= pattern[31:24];
                     data_valid_reg <= 1'b1;
                     busy_reg       <= 1'b1;
                  end else if (prbs_bytes != '0) begin
                     // Start with the PRBS phase. The first byte comes from SEED.
                     state_reg      <= PRBS;
                     lfsr_reg       <= seed_step[22:8];
                     data_reg       <= seed_step[7:0];
                     data_valid_reg <= 1'b1;
                     busy_reg       <= 1'b1;
                  end else begin
                     // Empty command: no bytes are sent, only the done pulse.
                     state_reg      <= FIN;
                     lfsr_reg       <= SEED;
                     data_valid_reg <= 1'b0;
                     busy_reg       <= 1'b0;
                     done_reg       <= 1'b1;
                  end
               end
            end

            PAT: begin
               if (transfer) begin
                  if (byte_idx_reg == 2'd3) begin
                     byte_idx_reg <= 2'd0;
                     if (rep_last) begin
                        if (prbs_len_reg != '0) begin
                           // Seamless hand-off: the first PRBS byte goes out
                           // on the edge that accepts the last pattern byte.
                           state_reg <= PRBS;
                           lfsr_reg  <= lfsr_step[22:8];
                           data_reg  <= lfsr_step[7:0];
                        end else begin
                           state_reg      <= FIN;
                           data_valid_reg <= 1'b0;
                           busy_reg       <= 1'b0;
                           done_reg       <= 1'b1;
                        end
                     end else begin
                        rep_cnt_reg <= rep_cnt_next;
                        data_reg    <= pat_bytes[0];
                     end
                  end else begin
                     byte_idx_reg <= byte_idx_next;
                     data_reg     <= pat_bytes[byte_idx_next];
                  end
               end
            end

            PRBS: begin
               if (transfer) begin
                  if (prbs_last) begin
                     state_reg      <= FIN;
                     data_valid_reg <= 1'b0;
                     busy_reg       <= 1'b0;
                     done_reg       <= 1'b1;
                  end else begin
                     prbs_cnt_reg <= prbs_cnt_next;
                     lfsr_reg     <= lfsr_step[22:8];
                     data_reg     <= lfsr_step[7:0];
                  end
               end
            end

            FIN: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg      <= IDLE;
               data_valid_reg <= 1'b0;
               busy_reg       <= 1'b0;
               done_reg       <= 1'b0;
            end
         endcase
      end
   end

`ifdef PRBS_TX_ERR_INJECT_EN
   logic err_flag_reg;

   // Arm on any err_inject pulse. Clear when the corrupted byte is accepted.
   // A fresh pulse in that same cycle re-arms the flag for the byte after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_flag_reg <= 1'b0;
      end else if (err_inject) begin
         err_flag_reg <= 1'b1;
      end else if (transfer) begin
         err_flag_reg <= 1'b0;
      end
   end

   // Only the output byte is flipped. The LFSR and the stored byte stay clean.
   assign data_out = data_reg ^ {7'b0, err_flag_reg & data_valid_reg};
`else
   assign data_out = data_reg;
`endif

   assign data_valid = data_valid_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_prbs_pattern_tx.sv
// tb_prbs_pattern_tx: directed test of prbs_pattern_tx.
// Expected byte streams are hand-computed. For PRBS-15 with SEED 7FFF the
// byte stream starts 00, 02, 00, 0C.

`timescale 1ns/1ps

module tb_prbs_pattern_tx;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] pattern;
   logic [3:0]  n;
   logic [15:0] prbs_bytes;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        done;
`ifdef PRBS_TX_ERR_INJECT_EN
   logic        err_inject;
`endif

   int checks = 0;
   int errors = 0;

   prbs_pattern_tx #(
      .SEED       (15'h7FFF),
      .PRBS_LEN_W (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pattern    (pattern),
      .n          (n),
      .prbs_bytes (prbs_bytes),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .done       (done)
`ifdef PRBS_TX_ERR_INJECT_EN
      ,
      .err_inject (err_inject)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and sample 1 ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge. Afterwards scramble the inputs to prove they were latched.
   task automatic do_start(input logic [31:0] p, input logic [3:0] nn, input logic [15:0] pb);
      @(negedge clk);
      pattern    = p;
      n          = nn;
      prbs_bytes = pb;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      pattern    = ~p;
      n          = ~nn;
      prbs_bytes = ~pb;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      start      = 1'b0;
      pattern    = 32'h0;
      n          = 4'h0;
      prbs_bytes = 16'h0;
      data_ready = 1'b1;
`ifdef PRBS_TX_ERR_INJECT_EN
      err_inject = 1'b0;
`endif
      repeat (3) next_cycle();
      checks++;
      if (data_out !== 8'h00 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got data=%h valid=%b busy=%b done=%b, expected 00 0 0 0",
                  data_out, data_valid, busy, done);
      end
      rst = 1'b0;
      next_cycle();
      checks++;
      if (data_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got valid=%b done=%b, expected 0 0", data_valid, done);
      end
      $display("reset: done");
   endtask

   task automatic test_pattern();
      logic [7:0] exp [8];
      exp = '{8'hA5, 8'hC3, 8'h0F, 8'h96, 8'hA5, 8'hC3, 8'h0F, 8'h96};
      data_ready = 1'b1;
      do_start(32'hA5C3_0F96, 4'd2, 16'd0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== exp[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL pattern_byte%0d: got data=%h valid=%b busy=%b, expected %h 1 1",
                     i, data_out, data_valid, busy, exp[i]);
         end
         $display("pattern: byte %0d = %h", i, data_out);
         next_cycle();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL pattern_done: got done=%b busy=%b valid=%b, expected 1 0 0", done, busy, data_valid);
      end
      next_cycle();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL pattern_done_pulse: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_prbs_only();
      logic [7:0] exp [3];
      exp = '{8'h00, 8'h02, 8'h00};
      data_ready = 1'b1;
      do_start(32'h1122_3344, 4'd0, 16'd3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== exp[i]) begin
            errors++;
            $display("FAIL prbs_byte%0d: got data=%h valid=%b, expected %h 1", i, data_out, data_valid, exp[i]);
         end
         $display("prbs: byte %0d = %h", i, data_out);
         next_cycle();
      end
      checks++;
      if (done !== 1'b1 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL prbs_done: got done=%b valid=%b, expected 1 0", done, data_valid);
      end
      next_cycle();
   endtask

   task automatic test_stall();
      logic [7:0] exp [6];
      logic [7:0] got [$];
      logic       rp [4];
      logic       prev_stall;
      logic [7:0] prev_data;
      bit         finished;
      exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h02};
      rp  = '{1'b1, 1'b0, 1'b0, 1'b1};
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      finished   = 1'b0;
      data_ready = 1'b1;
      do_start(32'h1234_5678, 4'd1, 16'd2);
      for (int c = 0; c < 80; c++) begin
         data_ready = rp[c % 4];
         if (prev_stall) begin
            checks++;
            if (data_valid !== 1'b1 || data_out !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: got data=%h valid=%b, expected %h 1", data_out, data_valid, prev_data);
            end
         end
         if (data_valid === 1'b1 && data_ready === 1'b1) begin
            got.push_back(data_out);
            $display("stall: transfer %0d = %h", got.size() - 1, data_out);
         end
         prev_stall = (data_valid === 1'b1) && !data_ready;
         prev_data  = data_out;
         next_cycle();
         if (done === 1'b1) begin
            finished = 1'b1;
            break;
         end
      end
      data_ready = 1'b1;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL stall_timeout: got no done pulse, expected done within 80 cycles");
      end
      checks++;
      if (got.size() != 6) begin
         errors++;
         $display("FAIL stall_count: got %0d transfers, expected 6", got.size());
      end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++;
            $display("FAIL stall_byte%0d: got %h, expected %h", i, got[i], exp[i]);
         end
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [6];
      bit         saw_done;
      exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h02};
      data_ready = 1'b1;
      do_start(32'hDEAD_BEEF, 4'd2, 16'd4);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== exp[i]) begin
            errors++;
            $display("FAIL abort_byte%0d: got data=%h valid=%b, expected %h 1", i, data_out, data_valid, exp[i]);
         end
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      checks++;
      if (data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: got valid=%b busy=%b done=%b, expected 0 0 0", data_valid, busy, done);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         if (done === 1'b1 || data_valid === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_quiet: got done/valid activity after reset, expected none");
      end
      $display("reset_mid: aborted after 3 bytes");
      do_start(32'hDEAD_BEEF, 4'd1, 16'd2);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== exp[i]) begin
            errors++;
            $display("FAIL restart_byte%0d: got data=%h valid=%b, expected %h 1", i, data_out, data_valid, exp[i]);
         end
         $display("reset_mid: restart byte %0d = %h", i, data_out);
         next_cycle();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL restart_done: got done=%b, expected 1", done);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [5];
      exp = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00};
      data_ready = 1'b1;
      do_start(32'hCAFE_F00D, 4'd1, 16'd1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== exp[i]) begin
            errors++;
            $display("FAIL busy_start_byte%0d: got data=%h valid=%b, expected %h 1", i, data_out, data_valid, exp[i]);
         end
         $display("back_to_back: byte %0d = %h", i, data_out);
         if (i == 1) begin
            start      = 1'b1;
            pattern    = 32'h0102_0304;
            n          = 4'd3;
            prbs_bytes = 16'd9;
         end else begin
            start = 1'b0;
         end
         next_cycle();
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_done: got done=%b valid=%b, expected 1 0", done, data_valid);
      end
      next_cycle();
      do_start(32'h5555_AAAA, 4'd0, 16'd0);
      checks++;
      if (done !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL empty_done: got done=%b valid=%b busy=%b, expected 1 0 0", done, data_valid, busy);
      end
      next_cycle();
      checks++;
      if (done !== 1'b0 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_after: got done=%b valid=%b, expected 0 0", done, data_valid);
      end
      $display("back_to_back: empty command done");
      next_cycle();
   endtask

`ifdef PRBS_TX_ERR_INJECT_EN
   task automatic test_err_inject();
      logic [7:0] exp [4];
      exp = '{8'hA5, 8'hC2, 8'h0F, 8'h96};
      data_ready = 1'b1;
      do_start(32'hA5C3_0F96, 4'd1, 16'd0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== exp[i]) begin
            errors++;
            $display("FAIL inject_byte%0d: got data=%h valid=%b, expected %h 1", i, data_out, data_valid, exp[i]);
         end
         $display("err_inject: byte %0d = %h", i, data_out);
         err_inject = (i == 0);
         next_cycle();
      end
      err_inject = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL inject_done: got done=%b, expected 1", done);
      end
      next_cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_pattern();
      test_prbs_only();
      test_stall();
      test_reset_mid();
      test_back_to_back();
`ifdef PRBS_TX_ERR_INJECT_EN
      test_err_inject();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so that the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200 us");
      $fatal(1, "watchdog expired");
   end

endmodule
